pc_redirect_unit: RTL and testbench

//  Program-counter register and next-PC selector for the MIPS core. Consumes JRControl

---
 rtl/pc_redirect_unit_if.sv | 33 +++
 rtl/pc_redirect_unit.sv | 135 +++++++++++++
 tb/tb_pc_redirect_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if
//   Bundles the next-PC selection inputs and the PC/flush outputs of the
//   program-counter redirect unit.
//   master : the pipeline side (drives decode/stall, observes PC and flags)
//   slave  : the redirect unit itself
//   Inputs : Stall, JRControl, JRTarget[31:0], Jump, JumpIndex[25:0],
//            Branch, Zero, BranchOffset[31:0]
//   Outputs: PC[31:0], PCPlus4[31:0], Flush, Pending, AlignFault
interface pc_redirect_unit_if;
    logic        Stall;
    logic        JRControl;
    logic [31:0] JRTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        Branch;
    logic        Zero;
    logic [31:0] BranchOffset;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Flush;
    logic        Pending;
    logic        AlignFault;

    modport master (
        output Stall, JRControl, JRTarget, Jump, JumpIndex, Branch, Zero, BranchOffset,
        input  PC, PCPlus4, Flush, Pending, AlignFault
    );

    modport slave (
        input  Stall, JRControl, JRTarget, Jump, JumpIndex, Branch, Zero, BranchOffset,
        output PC, PCPlus4, Flush, Pending, AlignFault
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
//   Program-counter register and next-PC selector. Chooses between PC+4, the
//   branch target, the jump target and the JR register target, holds the PC
//   under Stall, parks a redirect that arrives while stalled, and pulses Flush
//   in the cycle the PC shows a redirected target.
//   Ports:
//     clk      : system clock, rising edge
//     reset_n  : asynchronous reset, active low
//     bus      : pc_redirect_unit_if.slave (decode inputs, PC and status outputs)
//   Parameters:
//     RESET_VECTOR : PC after reset
//     EXC_VECTOR   : PC loaded on a misaligned target (alignment check only)
//   Configuration macro:
//     PC_ALIGN_CHECK_EN : misaligned targets trap to EXC_VECTOR and set the
//                         sticky AlignFault. Undefined: target bits [1:0] are
//                         cleared on load and AlignFault stays 0.
//
//   state | meaning
//   RUN   | normal fetch; redirects applied on the next unstalled edge
//   PEND  | a redirect was seen under Stall; parked target waits for Stall=0
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pc_redirect_unit_if.slave      bus
);

    typedef enum logic {RUN, PEND} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt;
    logic        flush_q;
    logic        pending_q;
    logic        fault_q;

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] sel_tgt;
    logic        redir;
    logic [31:0] sel_load;
    logic [31:0] pend_load;
    logic        sel_bad;
    logic        pend_bad;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_tgt   = pc_plus4 + (bus.BranchOffset << 2);
        j_tgt    = {pc_plus4[31:28], bus.JumpIndex, 2'b00};
        sel_tgt  = pc_plus4;
        redir    = 1'b0;
        if (bus.JRControl) begin
            sel_tgt = bus.JRTarget;
            redir   = 1'b1;
        end else if (bus.Jump) begin
            sel_tgt = j_tgt;
            redir   = 1'b1;
        end else if (bus.Branch && bus.Zero) begin
            sel_tgt = br_tgt;
            redir   = 1'b1;
        end
    end

    // The parked target is stored raw so the alignment rule is applied once,
    // at the moment it is actually loaded into the PC.
`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        sel_bad   = (sel_tgt[1:0] != 2'b00);
        pend_bad  = (pend_tgt[1:0] != 2'b00);
        sel_load  = sel_bad  ? EXC_VECTOR : sel_tgt;
        pend_load = pend_bad ? EXC_VECTOR : pend_tgt;
    end
`else
    always_comb begin
        sel_bad   = 1'b0;
        pend_bad  = 1'b0;
        sel_load  = {sel_tgt[31:2], 2'b00};
        pend_load = {pend_tgt[31:2], 2'b00};
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            pc_q      <= RESET_VECTOR;
            pend_tgt  <= 32'h0;
            flush_q   <= 1'b0;
            pending_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!bus.Stall) begin
                        pc_q    <= sel_load;
                        flush_q <= redir | sel_bad;
                        fault_q <= fault_q | sel_bad;
                    end else begin
                        flush_q <= 1'b0;
                        if (redir) begin
                            pend_tgt  <= sel_tgt;
                            pending_q <= 1'b1;
                            state     <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (!bus.Stall) begin
                        pc_q      <= pend_load;
                        flush_q   <= 1'b1;
                        fault_q   <= fault_q | pend_bad;
                        pending_q <= 1'b0;
                        state     <= RUN;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    pending_q <= 1'b0;
                    flush_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC         = pc_q;
    assign bus.PCPlus4    = pc_plus4;
    assign bus.Flush      = flush_q;
    assign bus.Pending    = pending_q;
    assign bus.AlignFault = fault_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    pc_redirect_unit_if bus ();

    pc_redirect_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Stall        = 1'b0;
        bus.JRControl    = 1'b0;
        bus.JRTarget     = 32'h0;
        bus.Jump         = 1'b0;
        bus.JumpIndex    = 26'h0;
        bus.Branch       = 1'b0;
        bus.Zero         = 1'b0;
        bus.BranchOffset = 32'h0;
    endtask

    // Loads an aligned PC via a JR so each scenario starts from a known address.
    task automatic set_pc(input logic [31:0] addr);
        idle_inputs();
        bus.JRControl = 1'b1;
        bus.JRTarget  = addr;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) step();
        checks++; if (bus.PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 32'h0); end
        checks++; if (bus.PCPlus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4 got=%h exp=%h", bus.PCPlus4, 32'h4); end
        checks++; if ({bus.Flush, bus.Pending, bus.AlignFault} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.Flush, bus.Pending, bus.AlignFault}); end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.PC !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.PC, 32'(i * 4)); end
            checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL seq_flush%0d got=%b exp=0", i, bus.Flush); end
        end
    endtask

    task automatic test_priority();
        set_pc(32'h0000_0100);
        bus.JRControl    = 1'b1;
        bus.JRTarget     = 32'h0000_2000;
        bus.Jump         = 1'b1;
        bus.JumpIndex    = 26'h0000_123;
        bus.Branch       = 1'b1;
        bus.Zero         = 1'b1;
        bus.BranchOffset = 32'h0000_0010;
        step();
        checks++; if (bus.PC !== 32'h0000_2000) begin failures++; $display("FAIL prio_jr_pc got=%h exp=%h", bus.PC, 32'h2000); end
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL prio_jr_flush got=%b exp=1", bus.Flush); end
        idle_inputs();
        step();
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL prio_flush_drop got=%b exp=0", bus.Flush); end
        checks++; if (bus.PC !== 32'h0000_2004) begin failures++; $display("FAIL prio_next_pc got=%h exp=%h", bus.PC, 32'h2004); end
        // Jump beats branch when JR is absent: 0x2004+4 -> {0, 0x40<<2}
        bus.Jump         = 1'b1;
        bus.JumpIndex    = 26'h0000_040;
        bus.Branch       = 1'b1;
        bus.Zero         = 1'b1;
        bus.BranchOffset = 32'h0000_0010;
        step();
        checks++; if (bus.PC !== 32'h0000_0100) begin failures++; $display("FAIL prio_jump_pc got=%h exp=%h", bus.PC, 32'h100); end
        idle_inputs();
    endtask

    task automatic test_branch();
        set_pc(32'h0000_0100);
        bus.Branch       = 1'b1;
        bus.Zero         = 1'b1;
        bus.BranchOffset = 32'hFFFF_FFFE;
        step();
        checks++; if (bus.PC !== 32'h0000_00FC) begin failures++; $display("FAIL br_taken_pc got=%h exp=%h", bus.PC, 32'hFC); end
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL br_taken_flush got=%b exp=1", bus.Flush); end
        set_pc(32'h0000_0100);
        bus.Branch       = 1'b1;
        bus.Zero         = 1'b0;
        bus.BranchOffset = 32'hFFFF_FFFE;
        step();
        checks++; if (bus.PC !== 32'h0000_0104) begin failures++; $display("FAIL br_not_taken_pc got=%h exp=%h", bus.PC, 32'h104); end
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL br_not_taken_flush got=%b exp=0", bus.Flush); end
        // Forward branch: 0x104 + 4 + (3<<2) = 0x114
        bus.Zero         = 1'b1;
        bus.BranchOffset = 32'h0000_0003;
        step();
        checks++; if (bus.PC !== 32'h0000_0114) begin failures++; $display("FAIL br_fwd_pc got=%h exp=%h", bus.PC, 32'h114); end
        idle_inputs();
    endtask

    task automatic test_jump();
        set_pc(32'h3000_0010);
        checks++; if (bus.PCPlus4 !== 32'h3000_0014) begin failures++; $display("FAIL jump_pcplus4 got=%h exp=%h", bus.PCPlus4, 32'h3000_0014); end
        bus.Jump      = 1'b1;
        bus.JumpIndex = 26'h0000_040;
        step();
        checks++; if (bus.PC !== 32'h3000_0100) begin failures++; $display("FAIL jump_pc got=%h exp=%h", bus.PC, 32'h3000_0100); end
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL jump_flush got=%b exp=1", bus.Flush); end
        idle_inputs();
    endtask

    task automatic test_stall_pend();
        set_pc(32'h0000_0100);
        bus.Stall = 1'b1;
        step();
        checks++; if (bus.PC !== 32'h0000_0100) begin failures++; $display("FAIL stall_hold_pc got=%h exp=%h", bus.PC, 32'h100); end
        checks++; if (bus.Pending !== 1'b0) begin failures++; $display("FAIL stall_no_pend got=%b exp=0", bus.Pending); end
        bus.Jump      = 1'b1;
        bus.JumpIndex = 26'h0000_100;
        step();
        checks++; if (bus.PC !== 32'h0000_0100) begin failures++; $display("FAIL pend_hold_pc1 got=%h exp=%h", bus.PC, 32'h100); end
        checks++; if (bus.Pending !== 1'b1) begin failures++; $display("FAIL pend_set got=%b exp=1", bus.Pending); end
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL pend_flush got=%b exp=0", bus.Flush); end
        // Later redirects while parked must be ignored.
        bus.JumpIndex = 26'h0000_200;
        bus.JRControl = 1'b1;
        bus.JRTarget  = 32'h0000_5000;
        repeat (2) step();
        checks++; if (bus.PC !== 32'h0000_0100) begin failures++; $display("FAIL pend_hold_pc3 got=%h exp=%h", bus.PC, 32'h100); end
        checks++; if (bus.Pending !== 1'b1) begin failures++; $display("FAIL pend_still got=%b exp=1", bus.Pending); end
        idle_inputs();
        step();
        checks++; if (bus.PC !== 32'h0000_0400) begin failures++; $display("FAIL pend_release_pc got=%h exp=%h", bus.PC, 32'h400); end
        checks++; if ({bus.Flush, bus.Pending} !== 2'b10) begin failures++; $display("FAIL pend_release_flags got=%b exp=10", {bus.Flush, bus.Pending}); end
        step();
        checks++; if (bus.PC !== 32'h0000_0404) begin failures++; $display("FAIL pend_after_pc got=%h exp=%h", bus.PC, 32'h404); end
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL pend_after_flush got=%b exp=0", bus.Flush); end
    endtask

    task automatic test_reset_mid_pend();
        set_pc(32'h0000_0200);
        bus.Stall     = 1'b1;
        bus.JRControl = 1'b1;
        bus.JRTarget  = 32'h0000_7000;
        step();
        checks++; if (bus.Pending !== 1'b1) begin failures++; $display("FAIL rstpend_setup got=%b exp=1", bus.Pending); end
        idle_inputs();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.PC !== 32'h0) begin failures++; $display("FAIL rstpend_pc got=%h exp=%h", bus.PC, 32'h0); end
        checks++; if (bus.Pending !== 1'b0) begin failures++; $display("FAIL rstpend_pending got=%b exp=0", bus.Pending); end
        step();
        reset_n = 1'b1;
        step();
        checks++; if (bus.PC !== 32'h0000_0004) begin failures++; $display("FAIL rstpend_discard got=%h exp=%h", bus.PC, 32'h4); end
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL rstpend_flush got=%b exp=0", bus.Flush); end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++; if (bus.PCPlus4 !== 32'h0) begin failures++; $display("FAIL wrap_pcplus4 got=%h exp=%h", bus.PCPlus4, 32'h0); end
        step();
        checks++; if (bus.PC !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", bus.PC, 32'h0); end
        checks++; if ({bus.Flush, bus.AlignFault} !== 2'b00) begin failures++; $display("FAIL wrap_flags got=%b exp=00", {bus.Flush, bus.AlignFault}); end
    endtask

    task automatic test_back_to_back();
        set_pc(32'h0000_0100);
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL b2b_flush1 got=%b exp=1", bus.Flush); end
        bus.Jump      = 1'b1;
        bus.JumpIndex = 26'h0000_100;
        step();
        checks++; if (bus.PC !== 32'h0000_0400) begin failures++; $display("FAIL b2b_pc got=%h exp=%h", bus.PC, 32'h400); end
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL b2b_flush2 got=%b exp=1", bus.Flush); end
        idle_inputs();
        step();
        checks++; if (bus.Flush !== 1'b0) begin failures++; $display("FAIL b2b_flush3 got=%b exp=0", bus.Flush); end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        logic        exp_fault;
        set_pc(32'h0000_0200);
        bus.JRControl = 1'b1;
        bus.JRTarget  = 32'h0000_1002;
        step();
`ifdef PC_ALIGN_CHECK_EN
        exp_pc    = 32'h8000_0180;
        exp_fault = 1'b1;
`else
        exp_pc    = 32'h0000_1000;
        exp_fault = 1'b0;
`endif
        checks++; if (bus.PC !== exp_pc) begin failures++; $display("FAIL align_pc got=%h exp=%h", bus.PC, exp_pc); end
        checks++; if (bus.AlignFault !== exp_fault) begin failures++; $display("FAIL align_fault got=%b exp=%b", bus.AlignFault, exp_fault); end
        checks++; if (bus.Flush !== 1'b1) begin failures++; $display("FAIL align_flush got=%b exp=1", bus.Flush); end
        idle_inputs();
        step();
        checks++; if (bus.PC !== exp_pc + 32'd4) begin failures++; $display("FAIL align_next_pc got=%h exp=%h", bus.PC, exp_pc + 32'd4); end
        checks++; if (bus.AlignFault !== exp_fault) begin failures++; $display("FAIL align_sticky got=%b exp=%b", bus.AlignFault, exp_fault); end
        // Misaligned target parked under stall, checked when released.
        set_pc(32'h0000_0300);
        bus.Stall     = 1'b1;
        bus.JRControl = 1'b1;
        bus.JRTarget  = 32'h0000_2006;
        step();
        idle_inputs();
        step();
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h8000_0180;
`else
        exp_pc = 32'h0000_2004;
`endif
        checks++; if (bus.PC !== exp_pc) begin failures++; $display("FAIL align_pend_pc got=%h exp=%h", bus.PC, exp_pc); end
        checks++; if (bus.AlignFault !== exp_fault) begin failures++; $display("FAIL align_pend_fault got=%b exp=%b", bus.AlignFault, exp_fault); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_priority();
        test_branch();
        test_jump();
        test_stall_pend();
        test_back_to_back();
        test_wrap();
        test_align();
        test_reset_mid_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
